// File: rtl/sr_latch_pkg.sv
// sr_latch_pkg
//   Shared definitions for the NAND SR latch driver: controller state
//   encoding, command opcodes, default timing constants and a small helper
//   used to size counters.
package sr_latch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2,
    CHECK = 2'd3
  } state_t;

  // Command opcodes: SET pulses Sbar low, RESET pulses Rbar low.
  localparam logic OP_SET   = 1'b1;
  localparam logic OP_RESET = 1'b0;

  // Default timing constants (clock cycles).
  localparam int DEF_PULSE_CYCLES   = 4;
  localparam int DEF_GAP_CYCLES     = 2;
  localparam int DEF_SYNC_STAGES    = 2;
  localparam int DEF_TIMEOUT_CYCLES = 16;

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync_ff.sv
// sync_ff
//   Multi-stage flip-flop synchronizer for a single asynchronous input.
//   All stages clear on a synchronous active-high reset.
// Ports:
//   clk  in  system clock
//   rst  in  synchronous active-high reset
//   d    in  asynchronous input
//   q    out synchronized output (last stage)
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/sr_latch_driver.sv
// sr_latch_driver
//   Drives an external cross-coupled NAND SR latch. Accepts set/reset
//   commands over a valid/ready handshake, issues one registered active-low
//   pulse of fixed width on Sbar or Rbar, holds both lines high for a fixed
//   gap, then watches the synchronized latch output until it matches the
//   commanded value or a timeout expires, and reports the outcome.
// Ports:
//   clk         in  system clock (rising edge)
//   rst         in  synchronous active-high reset
//   cmd_valid   in  command request
//   cmd_op      in  1 = set (Sbar low), 0 = reset (Rbar low)
//   cmd_ready   out high only in IDLE
//   Sbar, Rbar  out active-low latch inputs, registered, never low together
//   q_in        in  latch Q, asynchronous
//   q_sync      out synchronized latch Q
//   done_valid  out one-cycle completion strobe
//   done_err    out with done_valid: 1 = timeout, 0 = match
module sr_latch_driver
  import sr_latch_pkg::*;
#(
  parameter int PULSE_CYCLES   = DEF_PULSE_CYCLES,
  parameter int GAP_CYCLES     = DEF_GAP_CYCLES,
  parameter int SYNC_STAGES    = DEF_SYNC_STAGES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic cmd_valid,
  input  logic cmd_op,
  output logic cmd_ready,
  output logic Sbar,
  output logic Rbar,
  input  logic q_in,
  output logic q_sync,
  output logic done_valid,
  output logic done_err
);

  localparam int CNT_MAX = max_of(max_of(PULSE_CYCLES, GAP_CYCLES),
                                  max_of(SYNC_STAGES, TIMEOUT_CYCLES));
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] PULSE_LAST   = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             op_q, op_d;
  logic             sbar_q, sbar_d;
  logic             rbar_q, rbar_d;
  logic             ready_q, ready_d;
  logic             done_valid_q, done_valid_d;
  logic             done_err_q, done_err_d;
  logic             match;

  // Read-back path: latch Q crosses into the clk domain here.
  sync_ff #(
    .STAGES (SYNC_STAGES)
  ) u_q_sync (
    .clk (clk),
    .rst (rst),
    .d   (q_in),
    .q   (q_sync)
  );

  assign match = (q_sync == op_q);

  // State register: every control flop, including the latch drive lines,
  // resets so the latch sees high-high from the first reset edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      sbar_q       <= 1'b1;
      rbar_q       <= 1'b1;
      ready_q      <= 1'b0;
      done_valid_q <= 1'b0;
      done_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sbar_q       <= sbar_d;
      rbar_q       <= rbar_d;
      ready_q      <= ready_d;
      done_valid_q <= done_valid_d;
      done_err_q   <= done_err_d;
    end
  end

  // Captured opcode is data; it is only meaningful once a command is taken.
  always_ff @(posedge clk) begin
    op_q <= op_d;
  end

  // Next-state logic. The counter always restarts at zero on a state
  // change, so it never wraps.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        // ready_q is low in the cycle right after reset, blocking accepts.
        if (cmd_valid && ready_q) begin
          op_d    = cmd_op;
          state_d = PULSE;
        end
      end
      PULSE: begin
        if (cnt_q == PULSE_LAST) begin
          cnt_d   = '0;
          state_d = GAP;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          state_d = CHECK;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      CHECK: begin
        if (match || (cnt_q == TIMEOUT_LAST)) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // Output decode from the next state, registered so the latch lines change
  // only at clock edges. A single op bit selects at most one low line.
  always_comb begin
    sbar_d       = ~((state_d == PULSE) && (op_d == OP_SET));
    rbar_d       = ~((state_d == PULSE) && (op_d == OP_RESET));
    ready_d      = (state_d == IDLE);
    done_valid_d = (state_q == CHECK) && (state_d == IDLE);
    done_err_d   = done_valid_d && !match;
  end

  assign Sbar       = sbar_q;
  assign Rbar       = rbar_q;
  assign cmd_ready  = ready_q;
  assign done_valid = done_valid_q;
  assign done_err   = done_err_q;

endmodule
